// File: rtl/add_pkg.sv
// add_sched shared package
// Parameter defaults and the width helper
package add_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_tag_fifo.sv
// add_tag_fifo: show-ahead FIFO of requester tags
// Holds the owner of every adder operation in flight
module add_tag_fifo
  import add_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TW    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [TW-1:0]         push_tag,
  input  logic                  pop,
  output logic [TW-1:0]         head_tag,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int PW = clog2(DEPTH);

  logic [TW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_tag = mem[rd_ptr];

  // pointers wrap modulo DEPTH; count tracks occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // tag storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '{default: '0};
    end else if (do_push) begin
      mem[wr_ptr] <= push_tag;
    end
  end

endmodule

// File: rtl/add_sched.sv
// add_sched: round-robin sharing of one external adder
// Results return in order and are routed by the head tag
module add_sched
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic                  o_add_valid,
  input  logic                  i_add_ready,
  output logic [WIDTH-1:0]      o_add_a,
  output logic [WIDTH-1:0]      o_add_b,
  input  logic                  i_add_result_valid,
  input  logic [WIDTH-1:0]      i_add_result,
  output logic                  o_add_result_ready,
  output logic [NREQ-1:0]       o_resp_valid,
  input  logic [NREQ-1:0]       i_resp_ready,
  output logic [WIDTH-1:0]      o_resp_data,
  output logic [clog2(DEPTH):0] o_inflight,
  output logic                  o_err
);

  localparam int TW = clog2(NREQ);

  logic [TW-1:0] last_grant;
  logic [TW-1:0] grant;
  logic [TW-1:0] head_tag;
  logic          any_valid;
  logic          issue;
  logic          pop;
  logic          full;
  logic          empty;
  int            idx;

  // round-robin search starting just after the last issued requester
  always_comb begin
    grant     = last_grant;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any_valid && i_req_valid[idx]) begin
        grant     = TW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign o_add_valid = any_valid && !full;
  assign issue       = o_add_valid && i_add_ready;
  assign o_add_a     = i_req_a[int'(grant)*WIDTH +: WIDTH];
  assign o_add_b     = i_req_b[int'(grant)*WIDTH +: WIDTH];

  // one-hot accept to the granted requester on issue
  always_comb begin
    o_req_ready = '0;
    if (issue) o_req_ready[grant] = 1'b1;
  end

  // route the returning result to the owner of the oldest operation
  always_comb begin
    o_resp_valid       = '0;
    o_add_result_ready = 1'b1;
    pop                = 1'b0;
    if (!empty) begin
      o_resp_valid[head_tag] = i_add_result_valid;
      o_add_result_ready     = i_resp_ready[head_tag];
      pop = i_add_result_valid && i_resp_ready[head_tag];
    end
  end

  assign o_resp_data = i_add_result;

  // pointer advances only when an operation actually issues
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant <= TW'(NREQ - 1);
    else if (issue) last_grant <= grant;
  end

  // sticky flag for a result with no owner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) o_err <= 1'b0;
    else if (i_add_result_valid && empty) o_err <= 1'b1;
  end

  add_tag_fifo #(
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (issue),
    .push_tag (grant),
    .pop      (pop),
    .head_tag (head_tag),
    .full     (full),
    .empty    (empty),
    .count    (o_inflight)
  );

endmodule

// File: tb/tb_add_sched.sv
// tb_add_sched: directed checks of add_sched
// Inputs change on negedge, outputs sampled 1ns later
module tb_add_sched;

  localparam int W = 16;
  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] i_req_valid;
  logic [N-1:0] o_req_ready;
  logic [N*W-1:0] i_req_a;
  logic [N*W-1:0] i_req_b;
  logic         o_add_valid;
  logic         i_add_ready;
  logic [W-1:0] o_add_a;
  logic [W-1:0] o_add_b;
  logic         i_add_result_valid;
  logic [W-1:0] i_add_result;
  logic         o_add_result_ready;
  logic [N-1:0] o_resp_valid;
  logic [N-1:0] i_resp_ready;
  logic [W-1:0] o_resp_data;
  logic [2:0]   o_inflight;
  logic         o_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_sched #(.WIDTH(W), .NREQ(N), .DEPTH(D)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_req_a            (i_req_a),
    .i_req_b            (i_req_b),
    .o_add_valid        (o_add_valid),
    .i_add_ready        (i_add_ready),
    .o_add_a            (o_add_a),
    .o_add_b            (o_add_b),
    .i_add_result_valid (i_add_result_valid),
    .i_add_result       (i_add_result),
    .o_add_result_ready (o_add_result_ready),
    .o_resp_valid       (o_resp_valid),
    .i_resp_ready       (i_resp_ready),
    .o_resp_data        (o_resp_data),
    .o_inflight         (o_inflight),
    .o_err              (o_err)
  );

  function automatic logic [W-1:0] opa(input int n);
    return W'(100 * (n + 1));
  endfunction

  function automatic logic [W-1:0] opb(input int n);
    return W'(7 * (n + 1) + 1);
  endfunction

  function automatic logic [N-1:0] oh(input int n);
    logic [N-1:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic idle_inputs();
    i_req_valid        = '0;
    i_add_ready        = 1'b0;
    i_add_result_valid = 1'b0;
    i_add_result       = '0;
    i_resp_ready       = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    for (int n = 0; n < N; n++) begin
      i_req_a[n*W +: W] = opa(n);
      i_req_b[n*W +: W] = opb(n);
    end
    #1;
    checks++;
    if (o_inflight !== 3'd0) begin
      errors++; $display("FAIL rst_inflight got %0d exp 0", o_inflight);
    end
    checks++;
    if (o_err !== 1'b0) begin
      errors++; $display("FAIL rst_err got %b exp 0", o_err);
    end
    checks++;
    if (o_resp_valid !== 4'b0000 || o_add_result_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_resp got v=%b r=%b exp v=0000 r=1",
               o_resp_valid, o_add_result_ready);
    end
    checks++;
    if (o_add_valid !== 1'b0) begin
      errors++; $display("FAIL rst_addv_idle got %b exp 0", o_add_valid);
    end
    i_req_valid = 4'b1000;
    #1;
    checks++;
    if (o_add_valid !== 1'b1) begin
      errors++; $display("FAIL rst_addv_req got %b exp 1", o_add_valid);
    end
    @(negedge clk);
    i_req_valid = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic         pv;
    logic [W-1:0] pd;
    int           pt;
    int           exp_g;
    do_reset();
    i_req_valid  = '1;
    i_add_ready  = 1'b1;
    i_resp_ready = '1;
    pv = 1'b0; pd = '0; pt = 0; exp_g = 0;
    for (int c = 0; c < 8; c++) begin
      i_add_result_valid = pv;
      i_add_result       = pd;
      #1;
      checks++;
      if (o_req_ready !== oh(exp_g)) begin
        errors++;
        $display("FAIL rr_grant c=%0d got %b exp %b", c, o_req_ready, oh(exp_g));
      end
      checks++;
      if (o_add_a !== opa(exp_g) || o_add_b !== opb(exp_g)) begin
        errors++;
        $display("FAIL rr_ops c=%0d got %0d,%0d exp %0d,%0d",
                 c, o_add_a, o_add_b, opa(exp_g), opb(exp_g));
      end
      if (pv) begin
        checks++;
        if (o_resp_valid !== oh(pt) || o_resp_data !== pd) begin
          errors++;
          $display("FAIL rr_resp c=%0d got %b/%0d exp %b/%0d",
                   c, o_resp_valid, o_resp_data, oh(pt), pd);
        end
      end
      checks++;
      if (o_inflight !== ((c == 0) ? 3'd0 : 3'd1)) begin
        errors++; $display("FAIL rr_inflight c=%0d got %0d", c, o_inflight);
      end
      pv = 1'b1;
      pd = opa(exp_g) + opb(exp_g);
      pt = exp_g;
      exp_g = (exp_g + 1) % N;
      @(negedge clk);
    end
    i_req_valid        = '0;
    i_add_result_valid = pv;
    i_add_result       = pd;
    #1;
    checks++;
    if (o_resp_valid !== oh(pt) || o_resp_data !== 16'd429) begin
      errors++;
      $display("FAIL rr_last got %b/%0d exp %b/429", o_resp_valid, o_resp_data, oh(pt));
    end
    @(negedge clk);
    i_add_result_valid = 1'b0;
    #1;
    checks++;
    if (o_inflight !== 3'd0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain got inflight=%0d err=%b exp 0/0", o_inflight, o_err);
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    i_req_valid = 4'b0100;
    i_add_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (o_req_ready !== 4'b0100) begin
        errors++; $display("FAIL full_fill c=%0d got %b exp 0100", c, o_req_ready);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (o_inflight !== 3'd4 || o_req_ready !== 4'b0000 || o_add_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_stall got inf=%0d rdy=%b av=%b exp 4/0000/0",
               o_inflight, o_req_ready, o_add_valid);
    end
    i_add_result_valid = 1'b1;
    i_add_result       = 16'h00aa;
    i_resp_ready       = 4'b0100;
    #1;
    checks++;
    if (o_resp_valid !== 4'b0100 || o_add_result_ready !== 1'b1 ||
        o_req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL full_popcyc got v=%b rr=%b rdy=%b exp 0100/1/0000",
               o_resp_valid, o_add_result_ready, o_req_ready);
    end
    @(negedge clk);
    i_add_result_valid = 1'b0;
    #1;
    checks++;
    if (o_inflight !== 3'd3 || o_req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL full_resume got inf=%0d rdy=%b exp 3/0100", o_inflight, o_req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_inflight !== 3'd4) begin
      errors++; $display("FAIL full_refill got %0d exp 4", o_inflight);
    end
  endtask

  task automatic test_add_ready();
    int exp_seq [4] = '{0, 1, 2, 3};
    do_reset();
    i_req_valid  = '1;
    i_add_ready  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (o_req_ready !== oh(exp_seq[c])) begin
        errors++; $display("FAIL ar_pre c=%0d got %b", c, o_req_ready);
      end
      @(negedge clk);
    end
    i_add_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (o_req_ready !== 4'b0000 || o_add_valid !== 1'b1 || o_add_a !== opa(2)) begin
        errors++;
        $display("FAIL ar_hold c=%0d got rdy=%b av=%b a=%0d exp 0000/1/%0d",
                 c, o_req_ready, o_add_valid, o_add_a, opa(2));
      end
      @(negedge clk);
    end
    i_add_ready = 1'b1;
    for (int c = 2; c < 4; c++) begin
      #1;
      checks++;
      if (o_req_ready !== oh(exp_seq[c])) begin
        errors++;
        $display("FAIL ar_post c=%0d got %b exp %b", c, o_req_ready, oh(exp_seq[c]));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (o_inflight !== 3'd4 || o_add_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_full got inf=%0d av=%b exp 4/0", o_inflight, o_add_valid);
    end
  endtask

  task automatic test_hol();
    do_reset();
    i_req_valid = 4'b0010;
    i_add_ready = 1'b1;
    @(negedge clk);
    i_req_valid        = '0;
    i_add_result_valid = 1'b1;
    i_add_result       = 16'h1234;
    i_resp_ready       = 4'b1000;
    #1;
    checks++;
    if (o_add_result_ready !== 1'b0 || o_resp_valid !== 4'b0010) begin
      errors++;
      $display("FAIL hol_block got rr=%b v=%b exp 0/0010", o_add_result_ready, o_resp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_inflight !== 3'd1 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL hol_nopop got inf=%0d err=%b exp 1/0", o_inflight, o_err);
    end
    i_resp_ready = 4'b1010;
    #1;
    checks++;
    if (o_add_result_ready !== 1'b1) begin
      errors++; $display("FAIL hol_release got %b exp 1", o_add_result_ready);
    end
    @(negedge clk);
    i_add_result_valid = 1'b0;
    #1;
    checks++;
    if (o_inflight !== 3'd0) begin
      errors++; $display("FAIL hol_pop got %0d exp 0", o_inflight);
    end
  endtask

  task automatic test_err();
    do_reset();
    i_add_result_valid = 1'b1;
    i_add_result       = 16'h0055;
    #1;
    checks++;
    if (o_add_result_ready !== 1'b1 || o_resp_valid !== 4'b0000 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pre got rr=%b v=%b err=%b exp 1/0000/0",
               o_add_result_ready, o_resp_valid, o_err);
    end
    @(negedge clk);
    i_add_result_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (o_err !== 1'b1) begin
        errors++; $display("FAIL err_sticky c=%0d got %b exp 1", c, o_err);
      end
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (o_err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b exp 0", o_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_req_valid = '1;
    i_add_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (o_inflight !== 3'd3 || o_req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL mid_pre got inf=%0d rdy=%b exp 3/1000", o_inflight, o_req_ready);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (o_inflight !== 3'd0 || o_add_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_async got inf=%0d av=%b exp 0/1", o_inflight, o_add_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (o_req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_grant got %b exp 0001", o_req_ready);
    end
    i_req_valid        = '0;
    i_add_result_valid = 1'b1;
    @(negedge clk);
    i_add_result_valid = 1'b0;
    #1;
    checks++;
    if (o_err !== 1'b1) begin
      errors++; $display("FAIL mid_stale got %b exp 1", o_err);
    end
  endtask

  initial begin
    i_req_a = '0;
    i_req_b = '0;
    test_reset();
    test_round_robin();
    test_full_stall();
    test_add_ready();
    test_hol();
    test_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-003 The block SHALL have parameter DEPTH, default 4, maximum adder operations in flight (power of 2, >=2).
REQ-004 clk  input  1  sole clock; all state on posedge clk.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_req_valid  input  NREQ  per-requester operand-pair valid.
REQ-007 o_req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 i_req_a, i_req_b  input  NREQ*WIDTH each  packed operands; requester n in bits [n*WIDTH +: WIDTH].
REQ-009 o_add_valid  output  1  drives both adder operand valids.
REQ-010 i_add_ready  input  1  adder operand-side ready (pipe enable).
REQ-011 o_add_a, o_add_b  output  WIDTH each  operands of the granted requester.
REQ-012 i_add_result_valid, i_add_result  input  1, WIDTH  adder result stream.
REQ-013 o_add_result_ready  output  1  backpressure to adder result.
REQ-014 o_resp_valid  output  NREQ  result valid, one-hot to the owning requester.
REQ-015 i_resp_ready  input  NREQ  per-requester result ready.
REQ-016 o_resp_data  output  WIDTH  result, shared by all requesters.
REQ-017 o_inflight  output  clog2(DEPTH)+1  operations issued and not yet returned.
REQ-018 o_err  output  1  sticky: result arrived with no operation in flight.

Function
REQ-019 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ; last_grant updates only on an issue.
REQ-020 An issue SHALL occur in a cycle iff some i_req_valid bit is set, i_add_ready=1 and the tag FIFO is not full; o_add_valid = (any valid) && !full.
REQ-021 On issue the granted requester's o_req_ready SHALL be 1 and its ID SHALL be pushed to the tag FIFO in the same cycle; all other o_req_ready bits 0.
REQ-022 A full tag FIFO SHALL block issue even if a pop occurs in the same cycle.
REQ-023 Results return in issue order; head tag t SHALL route: o_resp_valid[t]=i_add_result_valid, o_resp_data=i_add_result, o_add_result_ready=i_resp_ready[t].
REQ-024 Pop SHALL occur iff i_add_result_valid && i_resp_ready[head tag] && FIFO non-empty.
REQ-025 With FIFO empty: o_resp_valid=0, o_add_result_ready=1, and any i_add_result_valid SHALL set o_err.
REQ-026 Simultaneous push and pop SHALL leave o_inflight unchanged; pointers wrap modulo DEPTH.
REQ-027 Issue path SHALL be combinational from inputs (zero-cycle grant); result routing combinational from FIFO head.

Reset
REQ-028 While reset_n=0: FIFO empty, o_inflight=0, o_err=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-029 Reset mid-operation SHALL discard all in-flight tags; results arriving after reset with no issue SHALL set o_err.
REQ-030 Outputs during reset: o_req_ready=0 is not required; o_add_valid follows REQ-020 with empty FIFO.

Structure
REQ-031 Shared package add_pkg SHALL hold defaults for WIDTH/NREQ/DEPTH and the tag width function clog2.
REQ-032 One sub-module add_tag_fifo (DEPTH x clog2(NREQ), show-ahead, full/empty/count) SHALL hold issue tags.
REQ-033 The adder itself is external; add_sched holds no datapath registers beyond the tag FIFO.

Verification
REQ-034 All 4 requesters valid continuously, i_add_ready=1, results returned 1 cycle later -> grants 0,1,2,3,0,... and each gets a+b of its own operands.
REQ-035 Only requester 2 valid, i_resp_ready=0 -> 4 issues, o_inflight=4, issue stalls; raise i_resp_ready[2] -> one pop, still no issue that cycle, issue next cycle.
REQ-036 i_add_ready=0 for 5 cycles with requesters valid -> all o_req_ready=0, last_grant unchanged, grant order resumes correctly.
REQ-037 Result pending for requester 1 with i_resp_ready[1]=0, i_resp_ready[3]=1 -> o_add_result_ready=0, no pop (head-of-line holds).
REQ-038 i_add_result_valid=1 with FIFO empty -> o_err=1 and stays 1 until reset_n=0.
REQ-039 Assert reset_n=0 with 3 in flight -> o_inflight=0 immediately, next grant to requester 0.
